// File: rtl/pro_binarize_pack.sv
// Sign-binarizes PRO_PARALLEL lanes per beat against per-lane thresholds and packs them into PACK_WIDTH-bit words.
// Completing beat -> out_valid next cycle; in_ready drops only while the 2-entry output buffer is full.
`timescale 1ns/1ps

module pro_bp_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic         full
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_push  = push && (count != 2'd2);
  assign do_pop   = pop && (count != 2'd0);
  assign head_dat = slot0;
  assign head_vld = (count != 2'd0);
  assign full     = (count == 2'd2);

  // slot0 is always the head, so the output comes straight from a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_dat;
          else               slot1 <= push_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module pro_binarize_pack #(
  parameter int PRO_PARALLEL = 16,
  parameter int PRO_WIDTH    = 8,
  parameter int PACK_WIDTH   = 64,
  parameter int CNT_W        = $clog2(PACK_WIDTH / PRO_PARALLEL) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PRO_PARALLEL*PRO_WIDTH-1:0] in_data,
  input  logic                              in_flush,
  input  logic                              thr_we,
  input  logic [$clog2(PRO_PARALLEL)-1:0]   thr_addr,
  input  logic [PRO_WIDTH-1:0]              thr_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PACK_WIDTH-1:0]             out_data,
  output logic [CNT_W-1:0]                  out_count
);

  localparam int GROUPS = PACK_WIDTH / PRO_PARALLEL;
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(GROUPS - 1);

  logic signed [PRO_WIDTH-1:0] thr [PRO_PARALLEL];
  logic [PRO_PARALLEL-1:0]     bits;
  logic [PACK_WIDTH-1:0]       pack;
  logic [PACK_WIDTH-1:0]       placed;
  logic [PACK_WIDTH-1:0]       merged;
  logic [CNT_W-1:0]            fill;
  logic [CNT_W-1:0]            push_count;
  logic [PACK_WIDTH+CNT_W-1:0] head_dat;
  logic                        accept;
  logic                        push;
  logic                        full;

  always_comb begin
    bits = '0;
    for (int i = 0; i < PRO_PARALLEL; i++)
      bits[i] = $signed(in_data[i*PRO_WIDTH +: PRO_WIDTH]) >= thr[i];
  end

  always_comb begin
    placed = '0;
    for (int g = 0; g < GROUPS; g++)
      if (fill == CNT_W'(g)) placed[g*PRO_PARALLEL +: PRO_PARALLEL] = bits;
  end

  assign in_ready   = !full;
  assign accept     = in_ready && (in_valid || in_flush);
  assign merged     = in_valid ? (pack | placed) : pack;
  assign push_count = fill + CNT_W'(in_valid);
  // a flush with nothing accumulated and no beat attached produces no word
  assign push       = accept && ((in_valid && (fill == LAST_FILL)) ||
                                 (in_flush && (in_valid || (fill != '0))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack <= '0;
      fill <= '0;
    end else if (push) begin
      pack <= '0;
      fill <= '0;
    end else if (accept && in_valid) begin
      pack <= merged;
      fill <= fill + CNT_W'(1);
    end
  end

  // beats in the write cycle still see the old threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PRO_PARALLEL; i++) thr[i] <= '0;
    end else if (thr_we) begin
      thr[thr_addr] <= thr_data;
    end
  end

  pro_bp_fifo2 #(
    .W(PACK_WIDTH + CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({push_count, merged}),
    .pop      (out_valid && out_ready),
    .head_dat (head_dat),
    .head_vld (out_valid),
    .full     (full)
  );

  assign out_data  = head_dat[PACK_WIDTH-1:0];
  assign out_count = head_dat[PACK_WIDTH +: CNT_W];

endmodule

// File: tb/tb_pro_binarize_pack.sv
// Bench for pro_binarize_pack at 4 lanes x 8 bits into 16-bit words: directed table, corner sequences, random vs queue model.
`timescale 1ns/1ps

module tb_pro_binarize_pack;

  localparam int P  = 4;
  localparam int W  = 8;
  localparam int PW = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [P*W-1:0] in_data = '0;
  logic          in_flush = 1'b0;
  logic          thr_we = 1'b0;
  logic [1:0]    thr_addr = '0;
  logic [W-1:0]  thr_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_data;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  pro_binarize_pack #(
    .PRO_PARALLEL(P),
    .PRO_WIDTH   (W),
    .PACK_WIDTH  (PW),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_flush  (in_flush),
    .thr_we    (thr_we),
    .thr_addr  (thr_addr),
    .thr_data  (thr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  int nvec = 0;
  int nerr = 0;
  bit last_acc;

  // reference model: thresholds, beats of the open word, queue of finished words
  logic [W-1:0]  m_thr [P];
  logic [P-1:0]  m_beats [$];
  logic [PW-1:0] m_wd [$];
  int            m_wc [$];

  typedef struct {
    logic          v;
    logic [P*W-1:0] d;
    logic          f;
    logic          we;
    logic [1:0]    a;
    logic [W-1:0]  td;
    logic          e_ov;
    logic [PW-1:0] e_data;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic v, input logic [P*W-1:0] d, input logic f,
                              input logic we, input logic [1:0] a, input logic [W-1:0] td,
                              input logic e_ov, input logic [PW-1:0] e_data, input logic [CW-1:0] e_cnt);
    vec_t r;
    r.v = v; r.d = d; r.f = f; r.we = we; r.a = a; r.td = td;
    r.e_ov = e_ov; r.e_data = e_data; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_wd.delete();
    m_wc.delete();
    for (int i = 0; i < P; i++) m_thr[i] = '0;
  endtask

  // called at posedge+1: drive, check against model, advance model, move to next posedge+1
  task automatic cyc(input logic v, input logic [P*W-1:0] d, input logic f, input logic we,
                     input logic [1:0] a, input logic [W-1:0] td, input logic ordy);
    logic [P-1:0]  b;
    logic [PW-1:0] word;
    bit            acc;
    in_valid = v; in_data = d; in_flush = f;
    thr_we = we; thr_addr = a; thr_data = td; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, m_wd.size() < 2);
    chk("out_valid", out_valid, m_wd.size() > 0);
    if (m_wd.size() > 0) begin
      chk("out_data", out_data, m_wd[0]);
      chk("out_count", out_count, m_wc[0]);
    end
    acc = (m_wd.size() < 2) && (v || f);
    for (int i = 0; i < P; i++) b[i] = $signed(d[i*W +: W]) >= $signed(m_thr[i]);
    if (m_wd.size() > 0 && ordy) begin
      void'(m_wd.pop_front());
      void'(m_wc.pop_front());
    end
    if (acc) begin
      if (v) m_beats.push_back(b);
      if (m_beats.size() == PW/P || (f && m_beats.size() > 0)) begin
        word = '0;
        foreach (m_beats[k]) word[k*P +: P] = m_beats[k];
        m_wd.push_back(word);
        m_wc.push_back(m_beats.size());
        m_beats.delete();
      end
    end
    if (we) m_thr[a] = td;
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A   = 32'h8000FF05;  // lanes {5,-1,0,-128}
  localparam logic [31:0] B   = 32'h01010101;
  localparam logic [31:0] MAX = 32'h7F7F7F7F;
  localparam logic [31:0] MIN = 32'h80808080;

  initial begin
    int acc_n;
    int guard;
    logic hv, hf;
    logic [31:0] hd;
    bit pending;

    model_reset();
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_count", out_count, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // directed table: words 5555, 6667 (threshold write overlapping a beat), 00FF, 0FFF
    tbl[0]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[1]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[2]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[3]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 8'hFF, 1, 16'h5555, 4);
    tbl[5]  = mk(1, A, 0, 1, 0, 8'h06, 0, 16'h0000, 0);
    tbl[6]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[7]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[8]  = mk(1, A, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0, 8'h00, 1, 16'h6667, 4);
    tbl[10] = mk(0, 0, 0, 1, 1, 8'h00, 0, 16'h0000, 0);
    tbl[11] = mk(1, B, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[12] = mk(1, B, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 8'h00, 1, 16'h00FF, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[16] = mk(1, B, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[17] = mk(1, B, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[18] = mk(1, B, 1, 0, 0, 8'h00, 0, 16'h0000, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 8'h00, 1, 16'h0FFF, 3);
    tbl[20] = mk(0, 0, 0, 0, 0, 8'h00, 0, 16'h0000, 0);
    for (int r = 0; r < 21; r++) begin
      chk($sformatf("tbl%0d_in_ready", r), in_ready, 1);
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].e_ov);
      if (tbl[r].e_ov) begin
        chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].e_data);
        chk($sformatf("tbl%0d_out_count", r), out_count, tbl[r].e_cnt);
      end
      cyc(tbl[r].v, tbl[r].d, tbl[r].f, tbl[r].we, tbl[r].a, tbl[r].td, 1'b1);
    end

    // backpressure: two words buffered, third waits; in_ready returns after first pop
    acc_n = 0; guard = 0;
    while (acc_n < 8 && guard < 40) begin
      cyc(1, MAX, 0, 0, 0, 0, 0);
      if (last_acc) acc_n++;
      guard++;
    end
    chk("bp_accepts", acc_n, 8);
    chk("bp_full_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) cyc(1, MAX, 0, 0, 0, 0, 0);
    cyc(1, MAX, 0, 0, 0, 0, 1);
    chk("bp_ready_after_pop", in_ready, 1);
    guard = 0;
    while (acc_n < 12 && guard < 40) begin
      cyc(1, MAX, 0, 0, 0, 0, 1);
      if (last_acc) acc_n++;
      guard++;
    end
    chk("bp_total_accepts", acc_n, 12);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0, 0, 1);

    // simultaneous push and pop with one entry held
    for (int k = 0; k < 4; k++) cyc(1, MAX, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, MIN, 0, 0, 0, 0, 0);
    cyc(1, MIN, 0, 0, 0, 0, 1);
    chk("pp_out_valid", out_valid, 1);
    chk("pp_out_data", out_data, 16'h0000);
    chk("pp_in_ready", in_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("pp_drained", out_valid, 0);

    // asynchronous reset mid-word with a word waiting and a nonzero threshold
    for (int k = 0; k < 4; k++) cyc(1, MAX, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 8'h40, 0);
    cyc(1, B, 0, 0, 0, 0, 0);
    cyc(1, B, 0, 0, 0, 0, 0);
    in_valid = 0; in_flush = 0; thr_we = 0; out_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) cyc(1, A, 0, 0, 0, 0, 0);
    chk("arst_fresh_word", out_data, 16'h5555);
    chk("arst_fresh_count", out_count, 4);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // randomized traffic with upstream holding unaccepted requests
    pending = 0; hv = 0; hf = 0; hd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pending) begin
        hv = ($urandom_range(0, 3) != 0);
        hd = $urandom;
        hf = ($urandom_range(0, 6) == 0);
      end
      cyc(hv, hd, hf, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
      pending = (hv || hf) && !last_acc;
    end
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
